// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the riscv32i instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    NEXT = 2'b00,
    JUMP = 2'b01,
    INDJ = 2'b10
  } PCsource_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_WAIT = 2'b01,
    F_HOLD = 2'b10,
    F_DROP = 2'b11
  } FetchState_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall > load > bubble.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [31:0]     load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_pc_plus4,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  logic [31:0]     instr_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_plus4_reg;
  logic            valid_reg;

  // PC fields are left untouched on flush/bubble; only valid and the opcode matter then.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg    <= NOP_INSTR;
      pc_reg       <= '0;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else if (flush) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (stall) begin
      instr_reg <= instr_reg;
    end else if (load) begin
      instr_reg    <= load_instr;
      pc_reg       <= load_pc;
      pc_plus4_reg <= load_pc_plus4;
      valid_reg    <= 1'b1;
    end else begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end
  end

  assign instr    = instr_reg;
  assign pc       = pc_reg;
  assign pc_plus4 = pc_plus4_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, one-outstanding imem fetch FSM, redirect handling and
// a one-entry hold buffer for responses that arrive while decode is stalled.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  PCsource_t       pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  input  logic [XLEN-1:0] alu_result_e,
  input  logic            stall_d,
  input  logic            flush_d,
  fetch_stage_if.master   imem,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  FetchState_t     state_reg, state_next;
  logic [XLEN-1:0] pc_f_reg, pc_f_next;
  logic [31:0]     hold_reg, hold_next;
  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            load;
  logic [31:0]     load_instr;

  assign redirect   = (pc_src_e != NEXT);
  assign target_raw = (pc_src_e == JUMP) ? pc_target_e : (alu_result_e & ~XLEN'(1));
  // Targets are word-aligned silently; misaligned jumps are not trapped here.
  assign target     = target_raw & ~XLEN'(3);
  assign pc_plus4_f = pc_f_reg + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= F_IDLE;
      pc_f_reg  <= RESET_PC;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_f_reg  <= pc_f_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_f_next  = pc_f_reg;
    hold_next  = hold_reg;
    case (state_reg)
      F_IDLE: begin
        if (redirect) pc_f_next = target;
        else          state_next = F_WAIT;
      end
      F_WAIT: begin
        if (redirect) begin
          pc_f_next  = target;
          state_next = imem.imem_rvalid ? F_IDLE : F_DROP;
        end else if (imem.imem_rvalid) begin
          if (stall_d) begin
            hold_next  = imem.imem_rdata;
            state_next = F_HOLD;
          end else begin
            pc_f_next  = pc_plus4_f;
            state_next = F_IDLE;
          end
        end
      end
      F_HOLD: begin
        if (redirect) begin
          pc_f_next  = target;
          state_next = F_IDLE;
        end else if (!stall_d) begin
          pc_f_next  = pc_plus4_f;
          state_next = F_IDLE;
        end
      end
      F_DROP: begin
        // The stale response must drain before a new request can be issued.
        if (redirect)         pc_f_next  = target;
        if (imem.imem_rvalid) state_next = F_IDLE;
      end
      default: state_next = F_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = 1'b0;
    load          = 1'b0;
    load_instr    = imem.imem_rdata;
    case (state_reg)
      F_IDLE: imem.imem_req = !redirect && !rst;
      F_WAIT: load = imem.imem_rvalid && !redirect && !stall_d;
      F_HOLD: begin
        load       = !redirect && !stall_d;
        load_instr = hold_reg;
      end
      default: ;
    endcase
  end

  assign imem.imem_addr = pc_f_reg;

  fetch_stage_if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush_d),
    .stall        (stall_d),
    .load         (load),
    .load_instr   (load_instr),
    .load_pc      (pc_f_reg),
    .load_pc_plus4(pc_plus4_f),
    .instr        (instr_d),
    .pc           (pc_d),
    .pc_plus4     (pc_plus4_d),
    .valid        (valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stall/redirect traffic,
// with a scoreboard checking every instruction handed to decode against the PC stream.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  PCsource_t   pc_src_e = NEXT;
  logic [31:0] pc_target_e = '0;
  logic [31:0] alu_result_e = '0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage #(
    .XLEN    (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .alu_result_e(alu_result_e),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .imem        (imem),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_deliv  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Stream restart events (redirects and resets), stamped with the edge they take effect on.
  typedef struct {
    int unsigned stamp;
    logic [31:0] pc;
  } ev_t;
  ev_t ev_q[$];

  task automatic drive_redirect(input PCsource_t src, input logic [31:0] v, input logic fl);
    logic [31:0] tgt;
    pc_src_e = src;
    flush_d  = fl;
    if (src == JUMP) begin
      pc_target_e  = v;
      alu_result_e = $urandom;
      tgt          = v & ~32'd3;
    end else begin
      alu_result_e = v;
      pc_target_e  = $urandom;
      tgt          = (v & ~32'd1) & ~32'd3;
    end
    ev_q.push_back('{edge_cnt + 1, tgt});
  endtask

  // Memory model: fixed latency, or random 1..4 cycles when mem_lat == 0.
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  initial begin
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem.imem_rvalid = 1'b0;
      if (rst) begin
        mem_cnt = 0;
      end else if (mem_cnt > 0) begin
        check("one_outstanding", 32'(imem.imem_req), 32'd0);
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = mem_addr ^ KEY;
        end
      end else if (imem.imem_req) begin
        mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
        mem_addr = imem.imem_addr;
      end
    end
  end

  // Scoreboard monitor: each fresh IF/ID load must be the next word of the current stream.
  logic [31:0] exp_pc = RST_PC;
  logic        prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      while (ev_q.size() > 0 && ev_q[0].stamp <= edge_cnt) begin
        exp_pc = ev_q[0].pc;
        void'(ev_q.pop_front());
      end
      if (valid_d && !prev_stall) begin
        check("sb_pc_d", pc_d, exp_pc);
        check("sb_instr_d", instr_d, exp_pc ^ KEY);
        check("sb_pc_plus4_d", pc_plus4_d, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      prev_stall = stall_d;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int deliv_start;
    logic got;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_d", 32'(valid_d), 32'd0);
    check("rst_instr_d", instr_d, NOP_INSTR);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_pc_plus4_d", pc_plus4_d, 32'd0);
    check("rst_imem_addr", imem.imem_addr, RST_PC);
    check("rst_imem_req", 32'(imem.imem_req), 32'd0);

    @(posedge clk); #1 rst = 1'b0;
    // 1-cycle memory: request every second cycle, with wrap from FFFF_FFFC to 0
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("seq_req", 32'(imem.imem_req), 32'(i % 2 == 0));
      if (i % 2 == 0) check("seq_addr", imem.imem_addr, RST_PC + 32'(4 * (i / 2)));
      check("seq_valid", 32'(valid_d), 32'(i >= 2 && i % 2 == 0));
      if (i < 6) begin
        @(posedge clk); #1;
      end
    end

    // Response for addr 8 arrives while decode is stalled for 3 cycles
    @(posedge clk); #1 stall_d = 1'b1;
    @(negedge clk); check("stall_req0", 32'(imem.imem_req), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("hold_req1", 32'(imem.imem_req), 32'd0);
    check("hold_valid1", 32'(valid_d), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("hold_req2", 32'(imem.imem_req), 32'd0);
    check("hold_valid2", 32'(valid_d), 32'd0);
    @(posedge clk); #1 stall_d = 1'b0;
    @(negedge clk); check("hold_req3", 32'(imem.imem_req), 32'd0);
    @(posedge clk); #1 mem_lat = 3;
    @(negedge clk);
    check("unstall_valid", 32'(valid_d), 32'd1);
    check("unstall_pc_d", pc_d, 32'd8);
    check("unstall_req", 32'(imem.imem_req), 32'd1);
    check("unstall_addr", imem.imem_addr, 32'd12);

    // JUMP while waiting on a 3-cycle response
    @(posedge clk); #1 drive_redirect(JUMP, 32'h0000_0103, 1'b1);
    @(negedge clk);
    @(posedge clk); #1 pc_src_e = NEXT; flush_d = 1'b0;
    @(negedge clk);
    check("drop_addr", imem.imem_addr, 32'h0000_0100);
    check("drop_req", 32'(imem.imem_req), 32'd0);
    check("drop_valid0", 32'(valid_d), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_req1", 32'(imem.imem_req), 32'd0);
    check("drop_valid1", 32'(valid_d), 32'd0);
    @(posedge clk); #1 mem_lat = 1;
    @(negedge clk);
    check("jump_req", 32'(imem.imem_req), 32'd1);
    check("jump_addr", imem.imem_addr, 32'h0000_0100);
    check("drop_valid2", 32'(valid_d), 32'd0);

    // INDJ taken in F_IDLE
    @(posedge clk); #1;
    @(posedge clk); #1 drive_redirect(INDJ, 32'h0000_2001, 1'b1);
    @(negedge clk);
    check("indj_req", 32'(imem.imem_req), 32'd0);
    check("indj_prev_valid", 32'(valid_d), 32'd1);
    @(posedge clk); #1 pc_src_e = NEXT; flush_d = 1'b0;
    @(negedge clk);
    check("indj_next_req", 32'(imem.imem_req), 32'd1);
    check("indj_next_addr", imem.imem_addr, 32'h0000_2000);

    // flush_d and stall_d together while IF/ID holds a real instruction
    @(posedge clk); #1;
    @(posedge clk); #1 stall_d = 1'b1; flush_d = 1'b1;
    @(negedge clk);
    check("pre_flush_valid", 32'(valid_d), 32'd1);
    check("pre_flush_pc", pc_d, 32'h0000_2000);
    @(posedge clk); #1 stall_d = 1'b0; flush_d = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(valid_d), 32'd0);
    check("flush_instr", instr_d, NOP_INSTR);

    // Randomized traffic against the scoreboard
    mem_lat     = 0;
    deliv_start = n_deliv;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      stall_d = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 6)
        drive_redirect(($urandom_range(0, 1) == 1) ? JUMP : INDJ, $urandom, 1'b1);
      else begin
        pc_src_e = NEXT;
        flush_d  = 1'b0;
      end
    end
    check("random_progress", 32'((n_deliv - deliv_start) > 100), 32'd1);

    // Reset in the middle of an F_WAIT with a 3-cycle memory
    @(posedge clk); #1 stall_d = 1'b0; pc_src_e = NEXT; flush_d = 1'b0; mem_lat = 3;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (imem.imem_req) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("req_before_reset", 32'(got), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    ev_q.push_back('{edge_cnt + 1, RST_PC});
    @(posedge clk); #1;
    @(negedge clk);
    check("rst2_valid_d", 32'(valid_d), 32'd0);
    check("rst2_instr_d", instr_d, NOP_INSTR);
    check("rst2_pc_d", pc_d, 32'd0);
    check("rst2_pc_plus4_d", pc_plus4_d, 32'd0);
    check("rst2_imem_addr", imem.imem_addr, RST_PC);
    check("rst2_imem_req", 32'(imem.imem_req), 32'd0);
    @(posedge clk); #1 rst = 1'b0; mem_lat = 1;
    @(negedge clk);
    check("post_rst_req", 32'(imem.imem_req), 32'd1);
    check("post_rst_addr", imem.imem_addr, RST_PC);
    deliv_start = n_deliv;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_rst_progress", 32'((n_deliv - deliv_start) >= 3), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage of the riscv32i pipeline. Owns the PC register and issues one-outstanding requests to a variable-latency instruction memory. Applies EX-stage redirects (PCsource_t) and drives the IF/ID pipeline register consumed by decode. Handles decode back-pressure through a one-entry hold buffer, and discards stale responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, data/address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
pc_src_e  in  PCsource_t(2)  NEXT / JUMP / INDJ from EX
pc_target_e  in  XLEN  branch/JAL target (PC+imm)
alu_result_e  in  XLEN  JALR target
stall_d  in  1  hold IF/ID (decode cannot accept)
flush_d  in  1  bubble IF/ID next cycle
imem_req  out  1  one-cycle request pulse
imem_addr  out  XLEN  request address (= pc_f)
imem_rvalid  in  1  response valid, ≥1 cycle after imem_req
imem_rdata  in  32  instruction word
instr_d  out  32  IF/ID instruction
pc_d  out  XLEN  IF/ID PC
pc_plus4_d  out  XLEN  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at edge):
  - pc_f=RESET_PC, state=F_IDLE, buffer empty.
  - imem_req=0, valid_d=0, instr_d=NOP (32'h0000_0013), pc_d=0, pc_plus4_d=0.
  - Reset wins over every other input, in every state (in-flight response is lost; the memory side is also reset).
- Redirect = (pc_src_e != NEXT).
  - JUMP target = pc_target_e.
  - INDJ target = {alu_result_e[31:1],1'b0}.
  - Target bits [1:0] are forced to 00; no misalignment trap.
- imem_addr = pc_f at all times. imem_req is combinational, asserted only in F_IDLE with no redirect and rst=0.
- States (FetchState_t):
  - F_IDLE:
    - redirect → pc_f=target, stay F_IDLE, no request.
    - else imem_req=1 → F_WAIT.
  - F_WAIT:
    - rvalid & redirect → discard data, pc_f=target → F_IDLE.
    - redirect & !rvalid → pc_f=target → F_DROP.
    - rvalid & !stall_d → IF/ID load {rdata, pc_f, pc_f+4, valid=1}, pc_f+=4 → F_IDLE.
    - rvalid & stall_d → capture rdata in buffer → F_HOLD.
    - else stay.
  - F_HOLD:
    - redirect → discard buffer, pc_f=target → F_IDLE.
    - !stall_d → IF/ID load from buffer, pc_f+=4 → F_IDLE.
    - else stay.
  - F_DROP:
    - rvalid → discard → F_IDLE.
    - redirect → pc_f=new target, stay (or → F_IDLE if rvalid same cycle).
- IF/ID register priority (highest first):
  1. rst
  2. flush_d → valid_d=0, instr_d=NOP; pc_d/pc_plus4_d don't-care, held.
  3. stall_d → hold all.
  4. load from F_WAIT/F_HOLD as above.
  5. otherwise bubble: valid_d=0, instr_d=NOP.
- flush_d and redirect are independent; the hazard unit normally asserts both together.
- Arithmetic: pc_f+4 wraps modulo 2^XLEN (32'hFFFF_FFFC+4 = 0).
- Throughput: at most one instruction per 2 cycles with 1-cycle memory (issue, response).
- Redirect-to-first-request latency: 1 cycle (or 1 cycle after the stale response in F_DROP).

Decomposition:
- DataTypes_pkg additions:
  - FetchState_t enum logic [1:0] {F_IDLE, F_WAIT, F_HOLD, F_DROP}.
  - localparam NOP_INSTR = 32'h0000_0013.
  - Reuse PCsource_t.
- Sub-module if_id_reg: IF/ID register with the rst/flush/stall/load priority above.
- PC-next mux and FSM stay in fetch_stage.

Test Plan:
- Reset, then 1-cycle memory returning rdata=addr^32'hA5A5_0000 → imem_req at addr 0,4,8 every 2nd cycle; valid_d pulses with pc_d=0,4,8, pc_plus4_d=4,8,12.
- Response at addr 4 arrives while stall_d=1 for 3 cycles → state F_HOLD, no new imem_req, IF/ID holds previous; then pc_d=4 appears the cycle after stall_d drops.
- pc_src_e=JUMP, pc_target_e=32'h0000_0103 while F_WAIT (memory latency 3) → stale response discarded (valid_d stays 0); next imem_addr=32'h0000_0100.
- pc_src_e=INDJ, alu_result_e=32'h0000_2001 in F_IDLE → no request that cycle; next cycle imem_req=1, imem_addr=32'h0000_2000.
- flush_d=1 and stall_d=1 together with valid_d=1 → next cycle valid_d=0, instr_d=32'h0000_0013.
- RESET_PC=32'hFFFF_FFFC: first fetch at FFFF_FFFC, pc_plus4_d=0, next imem_addr=0. Then rst=1 mid-F_WAIT → outputs return to reset values and imem_addr=RESET_PC.
